// File: rtl/wb_port_arbiter_pkg.sv
// Shared write-back definitions used by the functional units, the write-back
// bus and the write-port arbiter.
package wb_port_arbiter_pkg;

    // Number of physical register file write ports
    localparam int WB_SIZE = 4;

    // Physical register index width
    localparam int PREG_WIDTH = 7;

    // Architectural data width
    localparam int XLEN = 64;

    // Default number of result sources: ALU, MUL, DIV, LSU and friends
    localparam int SRC_NUM_DEF = 6;

    // One write-back request as produced by a functional unit
    typedef struct packed {
        logic [PREG_WIDTH-1:0] rd;
        logic [XLEN-1:0]       res;
    } wb_req_t;

    // Advance a rotating index by one, wrapping back to zero at n
    function automatic int wrapInc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_rr_multi_grant.sv
// Rotating-priority selector that grants up to M of N requests per cycle.
// The scan starts at the priority pointer; the k-th winner goes to port k.
module rr_multi_grant #(
    parameter int N     = 6,
    parameter int M     = 4,
    parameter int IDX_W = $clog2(N),
    parameter int CNT_W = $clog2(M + 1)
) (
    input  logic [N-1:0]          req_i,
    input  logic [IDX_W-1:0]      ptr_i,
    output logic [M-1:0][N-1:0]   portSel_o,
    output logic [N-1:0]          grant_o,
    output logic [IDX_W-1:0]      lastIdx_o,
    output logic [CNT_W-1:0]      grantCnt_o
);

    int idx;
    int taken;

    // Walk the requests from the pointer onward and hand out ports in order
    always_comb begin
        portSel_o = '0;
        grant_o   = '0;
        lastIdx_o = '0;
        idx       = 0;
        taken     = 0;
        for (int n = 0; n < N; n++) begin
            idx = (int'(ptr_i) + n) % N;
            if (req_i[idx] && (taken < M)) begin
                grant_o[idx]            = 1'b1;
                portSel_o[taken][idx]   = 1'b1;
                lastIdx_o               = idx[IDX_W-1:0];
                taken                   = taken + 1;
            end
        end
        grantCnt_o = taken[CNT_W-1:0];
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: shares the regfile write ports among the FU result
// sources with rotating priority, silently accepts writes to preg 0, and
// registers the winners onto the write-back bus one cycle later.
module wb_port_arbiter #(
    parameter int SRC_NUM    = wb_port_arbiter_pkg::SRC_NUM_DEF,
    parameter int WB_PORT    = wb_port_arbiter_pkg::WB_SIZE,
    parameter int PREG_WIDTH = wb_port_arbiter_pkg::PREG_WIDTH,
    parameter int DATA_WIDTH = wb_port_arbiter_pkg::XLEN
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [SRC_NUM-1:0]                src_valid,
    input  logic [SRC_NUM*PREG_WIDTH-1:0]     src_rd,
    input  logic [SRC_NUM*DATA_WIDTH-1:0]     src_res,
    output logic [SRC_NUM-1:0]                src_ready,
    output logic [WB_PORT-1:0]                wb_en,
    output logic [WB_PORT*PREG_WIDTH-1:0]     wb_rd,
    output logic [WB_PORT*DATA_WIDTH-1:0]     wb_res,
    output logic [WB_PORT*$clog2(SRC_NUM)-1:0] wb_src,
    output logic [31:0]                       conflict_cnt
);

    import wb_port_arbiter_pkg::*;

    localparam int IDX_W = $clog2(SRC_NUM);
    localparam int CNT_W = $clog2(WB_PORT + 1);

    logic [SRC_NUM-1:0]              realReq;
    logic [SRC_NUM-1:0]              nullReq;
    logic [SRC_NUM-1:0]              grant;
    logic [WB_PORT-1:0][SRC_NUM-1:0] portSel;
    logic [IDX_W-1:0]                lastIdx;
    logic [CNT_W-1:0]                grantCnt;
    int                              realCnt;
    logic                            overSub;

    logic [IDX_W-1:0]                ptr_q, ptr_d;
    logic [WB_PORT-1:0]              wbEn_q, wbEn_d;
    logic [WB_PORT*PREG_WIDTH-1:0]   wbRd_q, wbRd_d;
    logic [WB_PORT*DATA_WIDTH-1:0]   wbRes_q, wbRes_d;
    logic [WB_PORT*IDX_W-1:0]        wbSrc_q, wbSrc_d;
    logic [31:0]                     cnt_q, cnt_d;

    // Separate real writes from preg-0 writes, which never need a port
    always_comb begin
        realReq = '0;
        nullReq = '0;
        for (int s = 0; s < SRC_NUM; s++) begin
            if (src_rd[s*PREG_WIDTH +: PREG_WIDTH] == '0) begin
                nullReq[s] = src_valid[s];
            end else begin
                realReq[s] = src_valid[s];
            end
        end
    end

    // Count real requests to detect cycles where some of them must wait
    always_comb begin
        realCnt = 0;
        for (int s = 0; s < SRC_NUM; s++) begin
            if (realReq[s]) begin
                realCnt = realCnt + 1;
            end
        end
        overSub = (realCnt > WB_PORT);
    end

    rr_multi_grant #(
        .N     (SRC_NUM),
        .M     (WB_PORT),
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) uGrant (
        .req_i      (realReq),
        .ptr_i      (ptr_q),
        .portSel_o  (portSel),
        .grant_o    (grant),
        .lastIdx_o  (lastIdx),
        .grantCnt_o (grantCnt)
    );

    assign src_ready = nullReq | grant;

    // Route each granted source onto its port; idle ports keep stale data
    always_comb begin
        wbEn_d  = '0;
        wbRd_d  = wbRd_q;
        wbRes_d = wbRes_q;
        wbSrc_d = wbSrc_q;
        for (int k = 0; k < WB_PORT; k++) begin
            for (int s = 0; s < SRC_NUM; s++) begin
                if (portSel[k][s]) begin
                    wbEn_d[k]                            = 1'b1;
                    wbRd_d[k*PREG_WIDTH +: PREG_WIDTH]   = src_rd[s*PREG_WIDTH +: PREG_WIDTH];
                    wbRes_d[k*DATA_WIDTH +: DATA_WIDTH]  = src_res[s*DATA_WIDTH +: DATA_WIDTH];
                    wbSrc_d[k*IDX_W +: IDX_W]            = IDX_W'(s);
                end
            end
        end
    end

    // Next scan starts just past the last winner so refused sources move up
    always_comb begin
        ptr_d = ptr_q;
        if (grantCnt != '0) begin
            ptr_d = IDX_W'(wrapInc(int'(lastIdx), SRC_NUM));
        end
    end

    // Saturating count of cycles with more real requests than ports
    always_comb begin
        cnt_d = cnt_q;
        if (overSub && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // State registers, all cleared immediately by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q   <= '0;
            wbEn_q  <= '0;
            wbRd_q  <= '0;
            wbRes_q <= '0;
            wbSrc_q <= '0;
            cnt_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            wbEn_q  <= wbEn_d;
            wbRd_q  <= wbRd_d;
            wbRes_q <= wbRes_d;
            wbSrc_q <= wbSrc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wb_en        = wbEn_q;
    assign wb_rd        = wbRd_q;
    assign wb_res       = wbRes_q;
    assign wb_src       = wbSrc_q;
    assign conflict_cnt = cnt_q;

    // A source that was refused must still be presenting its result
    for (genvar s = 0; s < SRC_NUM; s++) begin : gHoldCheck
        holdValid: assert property (@(posedge clk) disable iff (!rst)
            (src_valid[s] && !src_ready[s]) |=> src_valid[s]);
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_wb_port_arbiter;

    localparam int NS = 6;
    localparam int NP = 4;
    localparam int PW = 7;
    localparam int DW = 64;
    localparam int IW = 3;

    logic                clk;
    logic                rst;
    logic [NS-1:0]       src_valid;
    logic [NS*PW-1:0]    src_rd;
    logic [NS*DW-1:0]    src_res;
    logic [NS-1:0]       src_ready;
    logic [NP-1:0]       wb_en;
    logic [NP*PW-1:0]    wb_rd;
    logic [NP*DW-1:0]    wb_res;
    logic [NP*IW-1:0]    wb_src;
    logic [31:0]         conflict_cnt;

    // Staged and currently driven source values
    logic                sV[NS];
    logic [PW-1:0]       sRd[NS];
    logic [DW-1:0]       sRes[NS];
    logic                dV[NS];
    logic [PW-1:0]       dRd[NS];
    logic [DW-1:0]       dRes[NS];

    // Behavioural model state
    int                  mP;
    logic [31:0]         mCnt;
    logic [NS-1:0]       mReady;
    logic                expEn[NP];
    logic [PW-1:0]       expRd[NP];
    logic [DW-1:0]       expRes[NP];
    int                  expSrc[NP];
    int                  grantQ[$];
    int                  nReal;

    int                  total;
    int                  bad;

    wb_port_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .src_valid    (src_valid),
        .src_rd       (src_rd),
        .src_res      (src_res),
        .src_ready    (src_ready),
        .wb_en        (wb_en),
        .wb_rd        (wb_rd),
        .wb_res       (wb_res),
        .wb_src       (wb_src),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack the per-source arrays onto the DUT buses
    always_comb begin
        src_valid = '0;
        src_rd    = '0;
        src_res   = '0;
        for (int s = 0; s < NS; s++) begin
            src_valid[s]         = dV[s];
            src_rd[s*PW +: PW]   = dRd[s];
            src_res[s*DW +: DW]  = dRes[s];
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mP     = 0;
        mCnt   = '0;
        mReady = '0;
        for (int k = 0; k < NP; k++) begin
            expEn[k]  = 1'b0;
            expRd[k]  = '0;
            expRes[k] = '0;
            expSrc[k] = 0;
        end
    endtask

    task automatic clearStage();
        for (int s = 0; s < NS; s++) begin
            sV[s]   = 1'b0;
            sRd[s]  = '0;
            sRes[s] = '0;
        end
    endtask

    // Present the staged values just after the next rising edge
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        for (int s = 0; s < NS; s++) begin
            dV[s]   = sV[s];
            dRd[s]  = sRd[s];
            dRes[s] = sRes[s];
        end
    endtask

    task automatic stageSrc(input int s, input logic [PW-1:0] rd, input logic [DW-1:0] res);
        sV[s]   = 1'b1;
        sRd[s]  = rd;
        sRes[s] = res;
    endtask

    // Compare the DUT with the model every cycle, then advance the model
    always @(negedge clk) begin
        if (!rst) begin
            modelReset();
            checkOutput("rst_en", 64'(wb_en), 64'd0);
            checkOutput("rst_rd", 64'(wb_rd), 64'd0);
            checkOutput("rst_src", 64'(wb_src), 64'd0);
            checkOutput("rst_cnt", 64'(conflict_cnt), 64'd0);
        end else begin
            checkOutput("cnt", 64'(conflict_cnt), 64'(mCnt));
            for (int k = 0; k < NP; k++) begin
                checkOutput("en", 64'(wb_en[k]), 64'(expEn[k]));
                if (expEn[k]) begin
                    checkOutput("rd", 64'(wb_rd[k*PW +: PW]), 64'(expRd[k]));
                    checkOutput("res", wb_res[k*DW +: DW], expRes[k]);
                    checkOutput("src", 64'(wb_src[k*IW +: IW]), 64'(expSrc[k]));
                end
            end
            grantQ.delete();
            nReal = 0;
            for (int n = 0; n < NS; n++) begin
                int s;
                s = (mP + n) % NS;
                if (dV[s] && (dRd[s] != 0)) begin
                    nReal++;
                    if (grantQ.size() < NP) grantQ.push_back(s);
                end
            end
            mReady = '0;
            for (int s = 0; s < NS; s++) begin
                if (dV[s] && (dRd[s] == 0)) mReady[s] = 1'b1;
            end
            foreach (grantQ[g]) mReady[grantQ[g]] = 1'b1;
            checkOutput("ready", 64'(src_ready), 64'(mReady));
            for (int k = 0; k < NP; k++) begin
                expEn[k] = (k < grantQ.size());
                if (k < grantQ.size()) begin
                    expRd[k]  = dRd[grantQ[k]];
                    expRes[k] = dRes[grantQ[k]];
                    expSrc[k] = grantQ[k];
                end
            end
            if (grantQ.size() > 0) mP = (grantQ[grantQ.size()-1] + 1) % NS;
            if ((nReal > NP) && (mCnt != 32'hFFFF_FFFF)) mCnt = mCnt + 32'd1;
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        clearStage();
        for (int s = 0; s < NS; s++) begin
            dV[s]   = 1'b0;
            dRd[s]  = '0;
            dRes[s] = '0;
        end
        modelReset();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;

        $display("[TB] under-subscription");
        clearStage();
        stageSrc(1, 7'd5, 64'hA1A1);
        stageSrc(4, 7'd9, 64'hB4B4);
        applyStimulus();
        @(negedge clk);
        checkOutput("us_ready", 64'(src_ready), 64'(6'b010010));
        clearStage();
        applyStimulus();
        @(negedge clk);
        checkOutput("us_en", 64'(wb_en), 64'(4'b0011));
        checkOutput("us_rd0", 64'(wb_rd[0 +: PW]), 64'd5);
        checkOutput("us_rd1", 64'(wb_rd[PW +: PW]), 64'd9);
        checkOutput("us_src0", 64'(wb_src[0 +: IW]), 64'd1);
        checkOutput("us_src1", 64'(wb_src[IW +: IW]), 64'd4);
        checkOutput("us_res0", wb_res[0 +: DW], 64'hA1A1);

        $display("[TB] wrap-around");
        clearStage();
        stageSrc(5, 7'd20, 64'h55);
        stageSrc(0, 7'd21, 64'h66);
        stageSrc(1, 7'd22, 64'h77);
        applyStimulus();
        @(negedge clk);
        checkOutput("wr_ready", 64'(src_ready), 64'(6'b100011));
        clearStage();
        applyStimulus();
        @(negedge clk);
        checkOutput("wr_en", 64'(wb_en), 64'(4'b0111));
        checkOutput("wr_src0", 64'(wb_src[0 +: IW]), 64'd5);
        checkOutput("wr_src1", 64'(wb_src[IW +: IW]), 64'd0);
        checkOutput("wr_src2", 64'(wb_src[2*IW +: IW]), 64'd1);
        checkOutput("wr_rd0", 64'(wb_rd[0 +: PW]), 64'd20);

        $display("[TB] null drop");
        clearStage();
        stageSrc(0, 7'd0, 64'h1);
        stageSrc(2, 7'd0, 64'h2);
        stageSrc(3, 7'd12, 64'hC3);
        applyStimulus();
        @(negedge clk);
        checkOutput("nd_ready", 64'(src_ready), 64'(6'b001101));
        clearStage();
        applyStimulus();
        @(negedge clk);
        checkOutput("nd_en", 64'(wb_en), 64'(4'b0001));
        checkOutput("nd_rd0", 64'(wb_rd[0 +: PW]), 64'd12);
        checkOutput("nd_src0", 64'(wb_src[0 +: IW]), 64'd3);

        $display("[TB] all null");
        clearStage();
        for (int s = 0; s < NS; s++) stageSrc(s, 7'd0, 64'(s));
        applyStimulus();
        @(negedge clk);
        checkOutput("an_ready", 64'(src_ready), 64'(6'b111111));
        clearStage();
        applyStimulus();
        @(negedge clk);
        checkOutput("an_en", 64'(wb_en), 64'd0);
        checkOutput("an_cnt", 64'(conflict_cnt), 64'd0);

        // Pointer back to zero for the rotation scenario
        @(posedge clk);
        #2 rst = 1'b0;
        modelReset();
        #2 rst = 1'b1;

        $display("[TB] over-subscription");
        clearStage();
        for (int s = 0; s < NS; s++) stageSrc(s, 7'(s + 1), 64'(32'h100 + s));
        applyStimulus();
        @(negedge clk);
        checkOutput("os0_ready", 64'(src_ready), 64'(6'b001111));
        for (int s = 0; s < 4; s++) stageSrc(s, 7'(s + 11), 64'(32'h200 + s));
        applyStimulus();
        @(negedge clk);
        checkOutput("os1_en", 64'(wb_en), 64'(4'b1111));
        checkOutput("os1_cnt", 64'(conflict_cnt), 64'd1);
        checkOutput("os1_src3", 64'(wb_src[3*IW +: IW]), 64'd3);
        checkOutput("os1_ready", 64'(src_ready), 64'(6'b110011));
        sV[0] = 1'b0;
        sV[1] = 1'b0;
        sV[4] = 1'b0;
        sV[5] = 1'b0;
        applyStimulus();
        @(negedge clk);
        checkOutput("os2_cnt", 64'(conflict_cnt), 64'd2);
        checkOutput("os2_src0", 64'(wb_src[0 +: IW]), 64'd4);
        checkOutput("os2_src1", 64'(wb_src[IW +: IW]), 64'd5);
        checkOutput("os2_src2", 64'(wb_src[2*IW +: IW]), 64'd0);
        checkOutput("os2_src3", 64'(wb_src[3*IW +: IW]), 64'd1);
        checkOutput("os2_rd2", 64'(wb_rd[2*PW +: PW]), 64'd11);
        checkOutput("os2_ready", 64'(src_ready), 64'(6'b001100));
        clearStage();
        applyStimulus();
        @(negedge clk);
        checkOutput("os3_en", 64'(wb_en), 64'(4'b0011));
        checkOutput("os3_rd0", 64'(wb_rd[0 +: PW]), 64'd13);

        // Leave the pointer at 2 so a missed pointer reset would reorder ports
        clearStage();
        stageSrc(0, 7'd30, 64'h30);
        stageSrc(1, 7'd31, 64'h31);
        applyStimulus();
        clearStage();
        applyStimulus();

        $display("[TB] reset mid-traffic");
        clearStage();
        for (int s = 0; s < 4; s++) stageSrc(s, 7'(s + 40), 64'(32'h400 + s));
        applyStimulus();
        #1 rst = 1'b0;
        modelReset();
        #1;
        checkOutput("mr_en", 64'(wb_en), 64'd0);
        checkOutput("mr_cnt", 64'(conflict_cnt), 64'd0);
        checkOutput("mr_src", 64'(wb_src), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mr_ready", 64'(src_ready), 64'(6'b001111));
        clearStage();
        applyStimulus();
        @(negedge clk);
        checkOutput("mr_en2", 64'(wb_en), 64'(4'b1111));
        for (int k = 0; k < NP; k++) begin
            checkOutput("mr_src_port", 64'(wb_src[k*IW +: IW]), 64'(k));
        end

        $display("[TB] random traffic");
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            #1;
            for (int s = 0; s < NS; s++) begin
                if (dV[s] && !mReady[s]) begin
                    sV[s]   = dV[s];
                    sRd[s]  = dRd[s];
                    sRes[s] = dRes[s];
                end else begin
                    sV[s]   = ($urandom_range(0, 99) < 65);
                    sRd[s]  = ($urandom_range(0, 4) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
                    sRes[s] = {$urandom, $urandom};
                end
            end
            applyStimulus();
            if ($urandom_range(0, 249) == 0) begin
                #1 rst = 1'b0;
                modelReset();
                #1 rst = 1'b1;
            end
        end

        clearStage();
        applyStimulus();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
